// File: rtl/tag_ctrl_if.sv
// tag_ctrl_if: lookup port, fill/invalidate port and tag RAM port of the L1
// tag controller. "slave" is the controller's view; "master" is the
// surrounding pipeline plus tag RAM.
interface tag_ctrl_if;
    // lookup port
    logic        lk_req;
    logic [7:0]  lk_index;
    logic [19:0] lk_tag;
    logic        lk_rdy;
    logic        lk_vld;
    logic        lk_hit;
    logic [1:0]  lk_way;
    logic [1:0]  lk_vic_way;
    logic        lk_vic_valid;
    logic        lk_vic_dirty;
    logic [19:0] lk_vic_tag;
    // fill / invalidate port
    logic        fl_req;
    logic        fl_inv;
    logic [7:0]  fl_index;
    logic [1:0]  fl_way;
    logic [19:0] fl_tag;
    logic        fl_dirty;
    logic        fl_rdy;
    // tag RAM port
    logic [7:0]  ram_r_index;
    logic [9:0]  ram_w_index;
    logic [21:0] ram_tag_in;
    logic        ram_wr_en;
    logic [87:0] ram_tag_out;
    logic        init_done;

    modport slave (
        input  lk_req, lk_index, lk_tag,
        output lk_rdy, lk_vld, lk_hit, lk_way,
        output lk_vic_way, lk_vic_valid, lk_vic_dirty, lk_vic_tag,
        input  fl_req, fl_inv, fl_index, fl_way, fl_tag, fl_dirty,
        output fl_rdy,
        output ram_r_index, ram_w_index, ram_tag_in, ram_wr_en,
        input  ram_tag_out,
        output init_done
    );

    modport master (
        output lk_req, lk_index, lk_tag,
        input  lk_rdy, lk_vld, lk_hit, lk_way,
        input  lk_vic_way, lk_vic_valid, lk_vic_dirty, lk_vic_tag,
        output fl_req, fl_inv, fl_index, fl_way, fl_tag, fl_dirty,
        input  fl_rdy,
        input  ram_r_index, ram_w_index, ram_tag_in, ram_wr_en,
        output ram_tag_out,
        input  init_done
    );
endinterface

// File: rtl/tag_ctrl.sv
// tag_ctrl: sequencing/arbitration for a 4-way, 256-set L1 tag array.
// Two-stage lookup (RAM read, then compare + victim pick), tree-PLRU per
// set, single-entry fill/invalidate writes.
// Build option TAG_SWEEP_EN: when defined, the array is cleared by a
// 1024-cycle write sweep after reset and RAM bit [21] is the valid bit;
// when undefined, a reset-cleared valid flop array is used instead and
// the block is ready the first cycle after reset.
module tag_ctrl (
    input  logic      clk,
    input  logic      rst,
    tag_ctrl_if.slave bus
);
    logic        running, lk_acc, fl_acc;
    logic        s1_vld_q;
    logic [7:0]  s1_idx_q;
    logic [19:0] s1_tag_q;
    logic        lk_vld_q, lk_hit_q, lk_vic_valid_q, lk_vic_dirty_q;
    logic [1:0]  lk_way_q, lk_vic_way_q;
    logic [19:0] lk_vic_tag_q;
    logic [2:0]  plru_q [256];
    logic [7:0]  r_index;
    logic [9:0]  w_index;
    logic [21:0] tag_in;
    logic        wr_en;

`ifdef TAG_SWEEP_EN
    typedef enum logic {SWEEP, RUN} state_t;
    state_t      state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic        sweeping;

    // state and sweep counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // sweep walks all 1024 entries once, then stays in RUN until reset
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == SWEEP) begin
            cnt_d = cnt_q + 10'd1;
            if (cnt_q == 10'd1023) state_d = RUN;
        end
    end

    assign sweeping = (state_q == SWEEP) && !rst;
    assign running  = (state_q == RUN) && !rst;
`else
    logic [1023:0] vld_q;
    logic [3:0]    s1_vbits_q;
    logic          unused_ram_vld;

    assign running        = !rst;
    // RAM valid bits are ignored in this build
    assign unused_ram_vld = ^{bus.ram_tag_out[87], bus.ram_tag_out[65],
                              bus.ram_tag_out[43], bus.ram_tag_out[21]};

    // valid flops: fill sets, invalidate clears, same timing as the RAM write
    always_ff @(posedge clk) begin
        if (rst) vld_q <= '0;
        else if (fl_acc) vld_q[{bus.fl_index, bus.fl_way}] <= !bus.fl_inv;
    end

    // snapshot the set's valid bits alongside the registered RAM read
    always_ff @(posedge clk) begin
        if (rst) s1_vbits_q <= '0;
        else if (lk_acc) s1_vbits_q <= vld_q[{bus.lk_index, 2'b00} +: 4];
    end
`endif

    assign fl_acc        = bus.fl_req && running;
    assign bus.fl_rdy    = running;
    assign bus.init_done = running;
    // a same-set write in this cycle holds the lookup off
    assign bus.lk_rdy    = running && !(bus.fl_req && (bus.fl_index == bus.lk_index));
    assign lk_acc        = bus.lk_req && bus.lk_rdy;

    // tag RAM read/write port; everything idles to zero under reset
    always_comb begin
        r_index = '0;
        w_index = '0;
        tag_in  = '0;
        wr_en   = 1'b0;
        if (lk_acc) r_index = bus.lk_index;
`ifdef TAG_SWEEP_EN
        if (sweeping) begin
            wr_en   = 1'b1;
            w_index = cnt_q;
        end
`endif
        if (fl_acc) begin
            wr_en   = 1'b1;
            w_index = {bus.fl_index, bus.fl_way};
            tag_in  = bus.fl_inv ? 22'h0 : {1'b1, bus.fl_dirty, bus.fl_tag};
        end
    end

    assign bus.ram_r_index = r_index;
    assign bus.ram_w_index = w_index;
    assign bus.ram_tag_in  = tag_in;
    assign bus.ram_wr_en   = wr_en;

    // stage 1: capture the accepted request while the RAM read is in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s1_idx_q <= '0;
            s1_tag_q <= '0;
        end else begin
            s1_vld_q <= lk_acc;
            if (lk_acc) begin
                s1_idx_q <= bus.lk_index;
                s1_tag_q <= bus.lk_tag;
            end
        end
    end

    logic [19:0] way_tag [4];
    logic [3:0]  way_dirty, way_v, match;
    logic        hit;
    logic [1:0]  hit_way, vic_way;
    logic [2:0]  plru_cur;

    // stage 2: 4-way compare, lowest matching way wins; victim is the lowest
    // invalid way, else the way the PLRU tree points at
    always_comb begin
        plru_cur = plru_q[s1_idx_q];
        for (int w = 0; w < 4; w++) begin
            way_tag[w]   = bus.ram_tag_out[22*w +: 20];
            way_dirty[w] = bus.ram_tag_out[22*w + 20];
`ifdef TAG_SWEEP_EN
            way_v[w]     = bus.ram_tag_out[22*w + 21];
`else
            way_v[w]     = s1_vbits_q[w];
`endif
            match[w]     = way_v[w] && (way_tag[w] == s1_tag_q);
        end
        hit     = |match;
        hit_way = 2'd0;
        for (int w = 3; w >= 0; w--)
            if (match[w]) hit_way = 2'(w);
        vic_way = plru_cur[0] ? {1'b1, plru_cur[2]} : {1'b0, plru_cur[1]};
        for (int w = 3; w >= 0; w--)
            if (!way_v[w]) vic_way = 2'(w);
    end

    // registered response, one-cycle lk_vld pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            lk_vld_q       <= 1'b0;
            lk_hit_q       <= 1'b0;
            lk_way_q       <= '0;
            lk_vic_way_q   <= '0;
            lk_vic_valid_q <= 1'b0;
            lk_vic_dirty_q <= 1'b0;
            lk_vic_tag_q   <= '0;
        end else begin
            lk_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                lk_hit_q       <= hit;
                lk_way_q       <= hit ? hit_way : 2'd0;
                lk_vic_way_q   <= vic_way;
                lk_vic_valid_q <= way_v[vic_way];
                lk_vic_dirty_q <= way_dirty[vic_way];
                lk_vic_tag_q   <= way_tag[vic_way];
            end
        end
    end

    assign bus.lk_vld       = lk_vld_q;
    assign bus.lk_hit       = lk_hit_q;
    assign bus.lk_way       = lk_way_q;
    assign bus.lk_vic_way   = lk_vic_way_q;
    assign bus.lk_vic_valid = lk_vic_valid_q;
    assign bus.lk_vic_dirty = lk_vic_dirty_q;
    assign bus.lk_vic_tag   = lk_vic_tag_q;

    // a touch points every tree bit on the path away from the touched way
    function automatic logic [2:0] touch(input logic [2:0] b, input logic [1:0] w);
        touch    = b;
        touch[0] = ~w[1];
        if (!w[1]) touch[1] = ~w[0];
        else       touch[2] = ~w[0];
    endfunction

    logic       hit_touch;
    logic [2:0] hit_plru_d, fill_base, fill_plru_d;

    // a same-set fill in the hit's update cycle composes on top of the hit
    always_comb begin
        hit_touch   = s1_vld_q && hit;
        hit_plru_d  = touch(plru_cur, hit_way);
        fill_base   = (hit_touch && (s1_idx_q == bus.fl_index)) ? hit_plru_d
                                                                : plru_q[bus.fl_index];
        fill_plru_d = touch(fill_base, bus.fl_way);
    end

    // PLRU state: stage-2 hit touch, then fill touch; invalidates leave it alone
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) plru_q[i] <= '0;
        end else begin
            if (hit_touch) plru_q[s1_idx_q] <= hit_plru_d;
            if (fl_acc && !bus.fl_inv) plru_q[bus.fl_index] <= fill_plru_d;
        end
    end
endmodule

// File: tb/tb_tag_ctrl.sv
// tb_tag_ctrl: directed + random stimulus for tag_ctrl. A behavioural tag
// RAM sits on the RAM port; a set-level model (arrays of tags/valid/dirty
// and the PLRU tree rule) predicts each lookup response, which a negedge
// monitor pops and compares.
module tb_tag_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tag_ctrl_if bus();

    tag_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // behavioural tag RAM: registered set read, one entry write per cycle;
    // contents start as garbage
    logic [21:0] mem [1024];
    bit          ram_inited = 1'b0;
    always @(posedge clk) begin
        if (!ram_inited) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 22'($urandom);
            ram_inited <= 1'b1;
        end else if (bus.ram_wr_en === 1'b1) begin
            mem[bus.ram_w_index] <= bus.ram_tag_in;
        end
        bus.ram_tag_out <= {mem[{bus.ram_r_index, 2'd3}], mem[{bus.ram_r_index, 2'd2}],
                            mem[{bus.ram_r_index, 2'd1}], mem[{bus.ram_r_index, 2'd0}]};
    end

    typedef struct {
        int          due;
        logic        hit;
        logic [1:0]  way;
        logic [1:0]  vw;
        logic        vv;
        logic        vd;
        logic [19:0] vt;
    } exp_t;

    exp_t        expq[$];
    int          total = 0, bad = 0, e = 0, resp_cnt = 0;
    logic        last_hit, last_vv, last_vd, seen_rdy;
    logic [1:0]  last_way, last_vw;
    logic [19:0] last_vt;

    // reference model of the array contents and replacement state
    logic [19:0] mtag   [256][4];
    logic        mval   [256][4];
    logic        mdirty [256][4];
    logic [2:0]  mplru  [256];
    bit          pend_vld;
    int          pend_idx, pend_way;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        e++;
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 256; i++) begin
            mplru[i] = 3'b000;
            for (int w = 0; w < 4; w++) begin
                mval[i][w] = 1'b0; mdirty[i][w] = 1'b0; mtag[i][w] = '0;
            end
        end
        pend_vld = 1'b0;
    endfunction

    // tree rule: bit0 picks the pair (0 = ways 0/1), bit1 / bit2 pick within
    // the pair; a touch makes the tree point away from the used way
    function automatic void mtouch(input int i, input int w);
        if (w < 2) begin mplru[i][0] = 1'b1; mplru[i][1] = (w == 0); end
        else       begin mplru[i][0] = 1'b0; mplru[i][2] = (w == 2); end
    endfunction

    function automatic exp_t predict(input int i, input logic [19:0] t);
        exp_t x;
        bit   found = 0;
        x.hit = 0; x.way = 0; x.due = 0;
        for (int w = 0; w < 4; w++)
            if (!x.hit && mval[i][w] && mtag[i][w] == t) begin x.hit = 1; x.way = 2'(w); end
        for (int w = 0; w < 4; w++)
            if (!found && !mval[i][w]) begin found = 1; x.vw = 2'(w); end
        if (!found) x.vw = mplru[i][0] ? (mplru[i][2] ? 2'd3 : 2'd2) : (mplru[i][1] ? 2'd1 : 2'd0);
        x.vv = mval[i][x.vw];
        x.vd = mdirty[i][x.vw];
        x.vt = mtag[i][x.vw];
        return x;
    endfunction

    // one cycle of stimulus; checks the combinational port behaviour and
    // updates the model in the order the hardware commits: pending hit
    // touch, then the fill, then the new lookup's prediction
    task automatic step(input bit lr, input logic [7:0] li, input logic [19:0] lt,
                        input bit fr, input bit finv, input logic [7:0] fi,
                        input logic [1:0] fw, input logic [19:0] ft, input bit fd);
        bit   rdy_m, lacc;
        exp_t x;
        @(negedge clk);
        bus.lk_req = lr; bus.lk_index = li; bus.lk_tag = lt;
        bus.fl_req = fr; bus.fl_inv = finv; bus.fl_index = fi;
        bus.fl_way = fw; bus.fl_tag = ft; bus.fl_dirty = fd;
        #1;
        rdy_m    = !(fr && fi == li);
        lacc     = lr && rdy_m;
        seen_rdy = bus.lk_rdy;
        chk("lk_rdy", bus.lk_rdy, rdy_m);
        chk("fl_rdy", bus.fl_rdy, 1);
        chk("ram_wr_en", bus.ram_wr_en, fr);
        if (fr) begin
            chk("ram_w_index", bus.ram_w_index, {fi, fw});
            chk("ram_tag_in", bus.ram_tag_in, finv ? 22'h0 : {1'b1, fd, ft});
        end
        if (lacc) chk("ram_r_index", bus.ram_r_index, li);
        tick();
        if (pend_vld) mtouch(pend_idx, pend_way);
        pend_vld = 1'b0;
        if (fr) begin
            if (finv) mval[fi][fw] = 1'b0;
            else begin
                mval[fi][fw] = 1'b1; mtag[fi][fw] = ft; mdirty[fi][fw] = fd;
                mtouch(fi, fw);
            end
        end
        if (lacc) begin
            x     = predict(li, lt);
            x.due = e + 1;
            expq.push_back(x);
            if (x.hit) begin pend_vld = 1'b1; pend_idx = li; pend_way = x.way; end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 8'h0, 20'h0, 0, 0, 8'h0, 2'd0, 20'h0, 0);
    endtask

    task automatic lookup(input logic [7:0] li, input logic [19:0] lt);
        step(1, li, lt, 0, 0, 8'h0, 2'd0, 20'h0, 0);
    endtask

    task automatic fill(input logic [7:0] fi, input logic [1:0] fw, input logic [19:0] ft, input bit fd);
        step(0, 8'h0, 20'h0, 1, 0, fi, fw, ft, fd);
    endtask

    // one-cycle reset, reset-value checks, then the array clear
    task automatic do_reset();
        int nerr;
        @(negedge clk);
        rst = 1'b1;
        bus.lk_req = 0; bus.lk_index = 0; bus.lk_tag = 0;
        bus.fl_req = 0; bus.fl_inv = 0; bus.fl_index = 0;
        bus.fl_way = 0; bus.fl_tag = 0; bus.fl_dirty = 0;
        #1;
        chk("rst_wr_en", bus.ram_wr_en, 0);
        chk("rst_init_done", bus.init_done, 0);
        chk("rst_lk_rdy", bus.lk_rdy, 0);
        tick();
        expq.delete();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_lk_vld", bus.lk_vld, 0);
        chk("rst_lk_hit_way", {bus.lk_hit, bus.lk_way}, 0);
        chk("rst_vic", {bus.lk_vic_way, bus.lk_vic_valid, bus.lk_vic_dirty, bus.lk_vic_tag}, 0);
`ifdef TAG_SWEEP_EN
        nerr = 0;
        for (int i = 0; i < 1024; i++) begin
            if (bus.ram_wr_en !== 1'b1 || bus.ram_w_index !== 10'(i) || bus.ram_tag_in !== 22'h0 ||
                bus.init_done !== 1'b0 || bus.lk_rdy !== 1'b0 || bus.fl_rdy !== 1'b0) nerr++;
            tick();
            @(negedge clk);
            #1;
        end
        chk("sweep_writes", nerr, 0);
        chk("sweep_done_wr_en", bus.ram_wr_en, 0);
`else
        nerr = 0;
`endif
        chk("init_done", bus.init_done, 1);
        chk("ready_after_init", {bus.lk_rdy, bus.fl_rdy}, 2'b11);
        tick();
    endtask

    // scoreboard monitor: every lk_vld must match the oldest prediction at
    // exactly its due edge
    always @(negedge clk) begin
        exp_t x;
        while (expq.size() > 0 && expq[0].due < e) begin
            chk("missing_lk_vld", 0, 1);
            void'(expq.pop_front());
        end
        if (bus.lk_vld === 1'b1) begin
            resp_cnt++;
            last_hit = bus.lk_hit; last_way = bus.lk_way; last_vw = bus.lk_vic_way;
            last_vv  = bus.lk_vic_valid; last_vd = bus.lk_vic_dirty; last_vt = bus.lk_vic_tag;
            if (expq.size() == 0) chk("unexpected_lk_vld", 1, 0);
            else begin
                x = expq.pop_front();
                chk("latency", e, x.due);
                chk("lk_hit", bus.lk_hit, x.hit);
                if (x.hit) chk("lk_way", bus.lk_way, x.way);
                chk("lk_vic_way", bus.lk_vic_way, x.vw);
                chk("lk_vic_valid", bus.lk_vic_valid, x.vv);
                if (x.vv) begin
                    chk("lk_vic_dirty", bus.lk_vic_dirty, x.vd);
                    chk("lk_vic_tag", bus.lk_vic_tag, x.vt);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish (edge %0d)", e);
        $fatal(1, "timeout");
    end

    initial begin
        int r0;
        rst = 1'b1;
        do_reset();

        // empty array: miss, victim way 0 invalid
        r0 = resp_cnt;
        lookup(8'h05, 20'h12345);
        idle(3);
        chk("t1_resp", resp_cnt - r0, 1);
        chk("t1_hit", last_hit, 0);
        chk("t1_vic_way", last_vw, 0);
        chk("t1_vic_valid", last_vv, 0);

        // fill then hit on the next cycle
        fill(8'h10, 2'd2, 20'hABCDE, 1);
        lookup(8'h10, 20'hABCDE);
        idle(3);
        chk("t2_hit", last_hit, 1);
        chk("t2_way", last_way, 2);

        // PLRU victim after fills 0..3 and hits 0, 2, 1
        for (int w = 0; w < 4; w++) fill(8'h07, 2'(w), 20'h100 + 20'(w), w[0]);
        lookup(8'h07, 20'h100);
        lookup(8'h07, 20'h102);
        lookup(8'h07, 20'h101);
        lookup(8'h07, 20'h999);
        idle(3);
        chk("t3_hit", last_hit, 0);
        chk("t3_vic_way", last_vw, 3);
        chk("t3_vic_valid", last_vv, 1);
        chk("t3_vic_tag", last_vt, 20'h103);
        chk("t3_vic_dirty", last_vd, 1);

        // same-set write and lookup: lookup held off, then hits the new tag
        step(1, 8'h20, 20'h55555, 1, 0, 8'h20, 2'd1, 20'h55555, 0);
        chk("t4_conflict_rdy", seen_rdy, 0);
        lookup(8'h20, 20'h55555);
        idle(3);
        chk("t4_hit", last_hit, 1);
        chk("t4_way", last_way, 1);

        // back-to-back lookups to four sets
        r0 = resp_cnt;
        lookup(8'h10, 20'hABCDE);
        lookup(8'h07, 20'h101);
        lookup(8'h20, 20'h55555);
        lookup(8'h05, 20'h12345);
        idle(3);
        chk("t5_resp", resp_cnt - r0, 4);
        chk("t5_last_hit", last_hit, 0);

        // random traffic over a few sets and tags
        for (int n = 0; n < 2000; n++) begin
            bit          lr, fr, finv, fd;
            logic [7:0]  li, fi;
            logic [1:0]  fw;
            logic [19:0] lt, ft;
            lr   = ($urandom_range(0, 9) < 7);
            li   = 8'($urandom_range(0, 7));
            lt   = 20'h100 + 20'($urandom_range(0, 5));
            fr   = ($urandom_range(0, 9) < 3);
            finv = ($urandom_range(0, 4) == 0);
            fi   = 8'($urandom_range(0, 7));
            fw   = 2'($urandom_range(0, 3));
            ft   = 20'h100 + 20'($urandom_range(0, 5));
            fd   = 1'($urandom_range(0, 1));
            step(lr, li, lt, fr, finv, fi, fw, ft, fd);
        end
        idle(4);
        chk("drain", expq.size(), 0);

        // reset the cycle after acceptance drops the lookup
        lookup(8'h10, 20'hABCDE);
        r0 = resp_cnt;
        do_reset();
        idle(3);
        chk("t6_no_resp", resp_cnt - r0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tag_ctrl.md
# tag_ctrl

Sequencing and arbitration controller for the 4-way, 256-set L1 tag array: 22-bit entries, 1024 total, registered 88-bit read of a whole set, and one write of a single entry per cycle. It sits between the cache pipeline and the tag RAM. It serves two requesters: a pipelined lookup port and a fill/invalidate port. It performs the 4-way compare, tracks tree-PLRU state per set, selects a victim on every lookup, and clears the array after reset.

## Interface
- No parameters. Geometry is fixed: 256 sets, 4 ways, 20-bit tag, entry = {valid[21], dirty[20], tag[19:0]}.
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- lk_req  in  1  lookup request
- lk_index  in  8  set index
- lk_tag  in  20  tag to compare
- lk_rdy  out  1  lookup accepted when lk_req && lk_rdy
- lk_vld  out  1  response valid (one-cycle pulse)
- lk_hit  out  1  hit
- lk_way  out  2  hitting way
- lk_vic_way  out  2  victim way
- lk_vic_valid  out  1  victim entry valid
- lk_vic_dirty  out  1  victim entry dirty
- lk_vic_tag  out  20  victim tag, for writeback address
- fl_req  in  1  write request
- fl_inv  in  1  1 = invalidate, 0 = fill
- fl_index  in  8  target set
- fl_way  in  2  target way
- fl_tag  in  20  fill tag
- fl_dirty  in  1  fill dirty bit
- fl_rdy  out  1  write accepted when fl_req && fl_rdy
- ram_r_index  out  8  to tag RAM read index
- ram_w_index  out  10  to tag RAM, {set, way}
- ram_tag_in  out  22  to tag RAM write data
- ram_wr_en  out  1  to tag RAM write enable
- ram_tag_out  in  88  from tag RAM; way w occupies [22w+21:22w]
- init_done  out  1  high once the array is cleared

## Operation
- States:
  - SWEEP: entered on rst. Exits to RUN after the write with counter = 1023.
  - RUN: normal operation. There is no other state.
- SWEEP behaviour:
  - A 10-bit counter starts at 0 and writes entry 0 (22'h0) to ram_w_index = counter, one entry per cycle.
  - lk_rdy = fl_rdy = init_done = 0 throughout.
- Lookup (RUN), stage 1:
  - Acceptance drives ram_r_index = lk_index combinationally.
  - lk_index and lk_tag are registered.
- Lookup, stage 2 (next cycle):
  - Compare the registered tag against all 4 ways of ram_tag_out.
  - hit = valid && tag equal. With multiple matches, the lowest way wins.
- Victim selection: the lowest-numbered invalid way. If all four ways are valid, the PLRU victim.
- Victim fields: lk_vic_valid, lk_vic_dirty and lk_vic_tag are taken from the victim entry.
- Tree-PLRU:
  - 3 bits per set in internal flops, reset to 0.
  - b0 selects a pair (0 = ways 0/1). b1 selects within 0/1; b2 selects within 2/3.
  - A touch of way w points all bits on the path away from w.
  - A hit touches lk_way at the end of stage 2. A fill touches fl_way on acceptance. An invalidate does not touch.
- Fill write: ram_w_index = {fl_index, fl_way}, ram_tag_in = {1, fl_dirty, fl_tag}, ram_wr_en = 1. Same cycle as acceptance.
- Invalidate write: ram_tag_in = 22'h0.
- fl_rdy = 1 in RUN. Writes are never stalled.
- Conflict rule:
  - If fl_req is high and fl_index == lk_index in the same cycle, lk_rdy = 0 and the write proceeds.
  - Otherwise lk_rdy = 1 in RUN, so back-to-back lookups are allowed.
- Simultaneous PLRU updates to the same set in one cycle (stage-2 hit touch and fill touch): apply the hit first, then the fill (fill wins).

## Timing
- Lookup latency is 2: accepted at cycle T, lk_vld = 1 in T+2 with registered outputs. Throughput is 1 per cycle.
- Responses have no backpressure.
- A write accepted in cycle T is visible to a lookup accepted in T+1 or later.
- Same-index write and lookup in cycle T: the lookup is held off by the conflict rule. Different-index: both proceed.
- A stage-2 PLRU update in cycle T is visible to the stage 2 of a lookup accepted in T.
- Sweep: rst high at edge E. Writes occur in cycles E+1 … E+1024. init_done = 1, lk_rdy = 1 and fl_rdy = 1 from cycle E+1025.
- Reset values:
  - lk_vld, lk_hit, lk_way, all lk_vic_* = 0
  - ram_wr_en = 0, ram_r_index = 0, ram_w_index = 0, ram_tag_in = 0
  - init_done = 0
  - PLRU = 0
- rst mid-operation: in-flight lookups are dropped (no lk_vld). The sweep restarts from 0.

## Configuration
- TAG_SWEEP_EN defined: behaviour as above; the RAM valid bit [21] is authoritative.
- TAG_SWEEP_EN undefined:
  - No SWEEP state. Instead, a 1024-bit valid flop array is cleared by rst.
  - init_done, lk_rdy and fl_rdy = 1 from the first cycle after rst.
  - Fill sets the valid bit; invalidate clears it. Compare and victim selection use the flop valid; RAM bit [21] is ignored.
  - The flop valid follows the same visibility timing as the RAM write.

## Test plan
- Reset and sweep: assert rst for 1 cycle → exactly 1024 ram_wr_en cycles with indices 0…1023 and data 0, then init_done = 1. A lookup of set 5, tag 0x12345 → lk_hit = 0, lk_vic_way = 0, lk_vic_valid = 0.
- Fill then hit: fill set 0x10, way 2, tag 0xABCDE, dirty 1; lookup the same set/tag next cycle → lk_vld at T+2, lk_hit = 1, lk_way = 2.
- PLRU victim: fill ways 0–3 of set 7, then hit ways 0, 2, 1 → a miss lookup gives lk_vic_way = 3, with lk_vic_valid = 1 and the filled tag and dirty bit.
- Conflict: fl_req and lk_req for set 0x20 in the same cycle → lk_rdy = 0, write performed. The lookup accepted next cycle hits the new tag.
- Back-to-back: 4 consecutive lookups to different sets → 4 consecutive lk_vld pulses in order, with correct hit/miss for each.
- Reset mid-lookup: rst in the cycle after acceptance → no lk_vld, and the sweep restarts at index 0.
